// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus bundle: instruction ROM port, execute redirect and decode handshake.
// The master modport is the fetch unit. The slave modport is the surrounding pipeline or bench.
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rd;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_pc;
  logic              halted;

  modport master (
    output imem_addr,
    input  imem_rd,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc,
    output halted
  );

  modport slave (
    input  imem_addr,
    output imem_rd,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc,
    input  halted
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, reads a same-cycle ROM, buffers {instr, pc}
// in a small prefetch FIFO for decode, and handles redirects and halting on a zero word.
module instr_fetch_unit #(
  parameter int              ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  instr_fetch_unit_if.master bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [ADDR_W-1:0] RESET_PC_AL = {RESET_PC[ADDR_W-1:2], 2'b00};

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  logic [0:0]        state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;

  logic [31:0]       mem_instr [DEPTH];
  logic [ADDR_W-1:0] mem_pc    [DEPTH];

  logic empty;
  logic full;
  logic pop;
  logic push;
  logic zero_word;
  logic [ADDR_W-1:0] redirect_target;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));
  assign pop   = !empty && bus.out_ready;

  // Redirect masks every other event: the ROM word presented in a redirect cycle is discarded.
  assign zero_word = (state == ST_RUN) && !bus.redirect_valid && (bus.imem_rd == 32'd0);
  assign push      = (state == ST_RUN) && !bus.redirect_valid && (bus.imem_rd != 32'd0)
                   && (!full || pop);

  assign redirect_target = {bus.redirect_pc[ADDR_W-1:2], 2'b00};

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_RUN;
      fetch_pc <= RESET_PC_AL;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (bus.redirect_valid) begin
      state    <= ST_RUN;
      fetch_pc <= redirect_target;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (zero_word) begin
        state <= ST_HALT;
      end
      if (push) begin
        fetch_pc <= fetch_pc + ADDR_W'(4);
        wr_ptr   <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; the outputs are gated by count, so stale data is never seen.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr[wr_ptr] <= bus.imem_rd;
      mem_pc[wr_ptr]    <= fetch_pc;
    end
  end

  assign bus.imem_addr = fetch_pc;
  assign bus.out_valid = !empty;
  assign bus.out_instr = empty ? 32'd0 : mem_instr[rd_ptr];
  assign bus.out_pc    = empty ? '0 : mem_pc[rd_ptr];
  assign bus.halted    = (state == ST_HALT);

  a_count_bound : assert property (@(posedge clk) disable iff (!rst_n)
    count <= CNT_W'(DEPTH));

  a_pc_aligned : assert property (@(posedge clk) disable iff (!rst_n)
    fetch_pc[1:0] == 2'b00);

  a_no_fetch_when_halted : assert property (@(posedge clk) disable iff (!rst_n)
    (state == ST_HALT) |-> !push);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a table of per-cycle vectors plus hand-written
// sequences for backpressure, redirect with pop, address wrap and mid-stream reset.
module tb_instr_fetch_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rom_alt = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  instr_fetch_unit_if #(.ADDR_W(8)) bus ();

  instr_fetch_unit #(
    .ADDR_W  (8),
    .RESET_PC(8'h00),
    .DEPTH   (2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  function automatic logic [31:0] rom(input logic alt, input logic [7:0] a);
    if (alt) begin
      case (a)
        8'hF8:   return 32'h11111113;
        8'hFC:   return 32'h22222223;
        8'h00:   return 32'h33333333;
        default: return 32'h0;
      endcase
    end
    case (a)
      8'h00:   return 32'h00300193;
      8'h04:   return 32'h00000293;
      8'h08:   return 32'h00328223;
      8'h0C:   return 32'h00428383;
      8'h10:   return 32'h0033f133;
      8'h14:   return 32'h00718663;
      8'h18:   return 32'h0033f333;
      8'h1C:   return 32'h00000463;
      8'h20:   return 32'h40338333;
      default: return 32'h0;
    endcase
  endfunction

  assign bus.imem_rd = rom(rom_alt, bus.imem_addr);

  typedef struct {
    logic        ready;
    logic        redir;
    logic [7:0]  rpc;
    logic        valid;
    logic [7:0]  pc;
    logic [31:0] instr;
    logic        halted;
    logic [7:0]  addr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic ready, input logic redir, input logic [7:0] rpc,
                              input logic valid, input logic [7:0] pc, input logic [31:0] instr,
                              input logic halted, input logic [7:0] addr);
    vec_t v;
    v.ready = ready; v.redir = redir; v.rpc = rpc;
    v.valid = valid; v.pc = pc; v.instr = instr; v.halted = halted; v.addr = addr;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic valid, input logic [7:0] pc,
                            input logic [31:0] instr, input logic halted, input logic [7:0] addr);
    check({tag, ".out_valid"}, 64'(bus.out_valid), 64'(valid));
    check({tag, ".out_pc"},    64'(bus.out_pc),    64'(pc));
    check({tag, ".out_instr"}, 64'(bus.out_instr), 64'(instr));
    check({tag, ".halted"},    64'(bus.halted),    64'(halted));
    check({tag, ".imem_addr"}, 64'(bus.imem_addr), 64'(addr));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.out_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 8'h00;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    bus.out_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 8'h00;
    step();
    step();
    check_outs("reset", 1'b0, 8'h00, 32'h0, 1'b0, 8'h00);
    rst_n = 1'b1;

    // Streaming with out_ready high, halt at 0x24, then redirect out of halt to 0x14.
    vecs.push_back(mk(1, 0, 8'h00, 1, 8'h00, 32'h00300193, 0, 8'h04));
    vecs.push_back(mk(1, 0, 8'h00, 1, 8'h04, 32'h00000293, 0, 8'h08));
    vecs.push_back(mk(1, 0, 8'h00, 1, 8'h08, 32'h00328223, 0, 8'h0C));
    vecs.push_back(mk(1, 0, 8'h00, 1, 8'h0C, 32'h00428383, 0, 8'h10));
    vecs.push_back(mk(1, 0, 8'h00, 1, 8'h10, 32'h0033f133, 0, 8'h14));
    vecs.push_back(mk(1, 0, 8'h00, 1, 8'h14, 32'h00718663, 0, 8'h18));
    vecs.push_back(mk(1, 0, 8'h00, 1, 8'h18, 32'h0033f333, 0, 8'h1C));
    vecs.push_back(mk(1, 0, 8'h00, 1, 8'h1C, 32'h00000463, 0, 8'h20));
    vecs.push_back(mk(1, 0, 8'h00, 1, 8'h20, 32'h40338333, 0, 8'h24));
    vecs.push_back(mk(1, 0, 8'h00, 0, 8'h00, 32'h00000000, 1, 8'h24));
    vecs.push_back(mk(1, 0, 8'h00, 0, 8'h00, 32'h00000000, 1, 8'h24));
    vecs.push_back(mk(1, 1, 8'h14, 0, 8'h00, 32'h00000000, 0, 8'h14));
    vecs.push_back(mk(1, 0, 8'h00, 1, 8'h14, 32'h00718663, 0, 8'h18));
    vecs.push_back(mk(1, 0, 8'h00, 1, 8'h18, 32'h0033f333, 0, 8'h1C));

    foreach (vecs[i]) begin
      bus.out_ready = vecs[i].ready;
      bus.redirect_valid = vecs[i].redir;
      bus.redirect_pc = vecs[i].rpc;
      step();
      check_outs($sformatf("vec%0d", i), vecs[i].valid, vecs[i].pc, vecs[i].instr,
                 vecs[i].halted, vecs[i].addr);
    end
    bus.redirect_valid = 1'b0;

    // Backpressure: five stalled cycles after the first valid, then drain in order.
    do_reset();
    step();
    check_outs("bp_first", 1'b1, 8'h00, 32'h00300193, 1'b0, 8'h04);
    for (int k = 0; k < 5; k++) begin
      step();
      check_outs($sformatf("bp_hold%0d", k), 1'b1, 8'h00, 32'h00300193, 1'b0, 8'h08);
    end
    bus.out_ready = 1'b1;
    step();
    check_outs("bp_rel0", 1'b1, 8'h04, 32'h00000293, 1'b0, 8'h0C);
    step();
    check_outs("bp_rel1", 1'b1, 8'h08, 32'h00328223, 1'b0, 8'h10);

    // FIFO holds 0x08 and 0x0c; redirect to an unaligned target in the same cycle as a pop.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 8'h1F;
    step();
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 8'h00;
    check_outs("rp_bubble", 1'b0, 8'h00, 32'h0, 1'b0, 8'h1C);
    step();
    check_outs("rp_t0", 1'b1, 8'h1C, 32'h00000463, 1'b0, 8'h20);
    step();
    check_outs("rp_t1", 1'b1, 8'h20, 32'h40338333, 1'b0, 8'h24);
    step();
    check_outs("rp_halt", 1'b0, 8'h00, 32'h0, 1'b1, 8'h24);

    // Address wrap through 0xFC -> 0x00 on the alternate image.
    do_reset();
    rom_alt = 1'b1;
    bus.out_ready = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 8'hF8;
    step();
    bus.redirect_valid = 1'b0;
    check_outs("wr_bubble", 1'b0, 8'h00, 32'h0, 1'b0, 8'hF8);
    step();
    check_outs("wr_f8", 1'b1, 8'hF8, 32'h11111113, 1'b0, 8'hFC);
    step();
    check_outs("wr_fc", 1'b1, 8'hFC, 32'h22222223, 1'b0, 8'h00);
    step();
    check_outs("wr_00", 1'b1, 8'h00, 32'h33333333, 1'b0, 8'h04);
    step();
    check_outs("wr_halt", 1'b0, 8'h00, 32'h0, 1'b1, 8'h04);

    // Asynchronous reset mid-stream with two entries buffered.
    do_reset();
    rom_alt = 1'b0;
    step();
    step();
    check_outs("mr_full", 1'b1, 8'h00, 32'h00300193, 1'b0, 8'h08);
    #2;
    rst_n = 1'b0;
    #1;
    check_outs("mr_async", 1'b0, 8'h00, 32'h0, 1'b0, 8'h00);
    step();
    check_outs("mr_held", 1'b0, 8'h00, 32'h0, 1'b0, 8'h00);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    step();
    check_outs("mr_re0", 1'b1, 8'h00, 32'h00300193, 1'b0, 8'h04);
    step();
    check_outs("mr_re1", 1'b1, 8'h04, 32'h00000293, 1'b0, 8'h08);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
